wb_uart_fifo_slave: RTL and testbench



---
 rtl/wb_uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/wb_uart_fifo_slave.sv | 183 ++++++++++++++++++
 tb/tb_wb_uart_fifo_slave.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and TX sequencer states
// for the buffered Wishbone UART slave.
package wb_uart_pkg;

    // Register offsets, decoded from adr_i[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_CLEAR  = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_VALID    = 0;
    localparam int ST_TX_NOT_FULL = 1;
    localparam int ST_TX_IDLE     = 2;
    localparam int ST_OVERRUN     = 3;
    localparam int ST_RX_COUNT    = 8;
    localparam int ST_TX_COUNT    = 16;

    // CTRL bit positions
    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    // TX launch sequencer: LAUNCH/GUARD give the transmitter time to raise busy
    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LAUNCH = 2'd1,
        TX_GUARD  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head, occupancy count and
// push+pop in the same cycle allowed even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array
    // NOTE: the data array has no reset; only pointers and count define validity,
    // which keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart_fifo_slave.sv
// Wishbone pipelined slave in front of a byte UART: RX/TX FIFOs, STATUS with
// occupancy counts, sticky RX overrun, retry on full TX, level interrupt.
module wb_uart_fifo_slave
    import wb_uart_pkg::*;
#(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic        clk_bus,
    input  logic        rst_bus_n,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    output logic        ack_o,
    output logic        rty_o,
    output logic        err_o,
    output logic        stall_o,
    output logic        irq_o,
    input  logic [7:0]  uart_dat_i,
    input  logic        uart_ready,
    output logic        uart_clear,
    output logic [7:0]  uart_dat_o,
    output logic        uart_start,
    input  logic        uart_busy
);
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    logic             accept;
    logic [1:0]       reg_sel;
    logic             data_read;
    logic             data_write;
    logic             retry;
    logic [31:0]      rdata;
    logic [31:0]      status;
    logic [1:0]       ctrl;
    logic             overrun;
    logic             overrun_set;
    logic             tx_idle;

    logic             rx_pop;
    logic             rx_full;
    logic             rx_empty;
    logic [7:0]       rx_head;
    logic [RX_CW-1:0] rx_count;

    logic             tx_push;
    logic             tx_pop;
    logic             tx_full;
    logic             tx_empty;
    logic [7:0]       tx_head;
    logic [TX_CW-1:0] tx_count;

    tx_state_t        tx_state;
    tx_state_t        tx_state_next;

    logic             unused_bits;

    assign unused_bits = &{1'b0, adr_i[31:4], adr_i[1:0], dat_i[31:8], sel_i[3:1]};

    assign err_o   = 1'b0;
    assign stall_o = 1'b0;

    assign accept     = cyc_i & stb_i;
    assign reg_sel    = adr_i[3:2];
    assign data_read  = accept & ~we_i & (reg_sel == REG_DATA);
    assign data_write = accept &  we_i & (reg_sel == REG_DATA) & sel_i[0];
    assign retry      = data_write & tx_full;
    assign tx_push    = data_write & ~tx_full;
    assign rx_pop     = data_read & ~rx_empty;

    // Every received byte is consumed immediately; it lands in the FIFO or is lost
    assign uart_clear  = uart_ready;
    assign overrun_set = uart_ready & rx_full & ~rx_pop;
    assign tx_idle     = tx_empty & (tx_state == TX_IDLE);

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_bus),
        .rst_n (rst_bus_n),
        .push  (uart_ready),
        .pop   (rx_pop),
        .din   (uart_dat_i),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_bus),
        .rst_n (rst_bus_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (dat_i[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // STATUS snapshot and read-data mux, both from pre-edge state
    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        status                      = '0;
        status[ST_RX_VALID]         = ~rx_empty;
        status[ST_TX_NOT_FULL]      = ~tx_full;
        status[ST_TX_IDLE]          = tx_idle;
        status[ST_OVERRUN]          = overrun;
        status[ST_RX_COUNT +: 8]    = 8'(rx_count);
        status[ST_TX_COUNT +: 8]    = 8'(tx_count);

        rdata = '0;
        case (reg_sel)
            REG_DATA:   if (!rx_empty) rdata = {23'd0, 1'b1, rx_head};
            REG_STATUS: rdata = status;
            REG_CTRL:   rdata = {30'd0, ctrl};
            default:    rdata = '0;
        endcase
    end

    // Bus termination: one-cycle ack or retry, read data alongside
    always_ff @(posedge clk_bus or negedge rst_bus_n) begin
        if (!rst_bus_n) begin
            ack_o <= 1'b0;
            rty_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= accept & ~retry;
            rty_o <= retry;
            dat_o <= (accept & ~we_i) ? rdata : '0;
        end
    end

    // CTRL register, sticky overrun (a new overrun beats a same-cycle clear) and interrupt
    always_ff @(posedge clk_bus or negedge rst_bus_n) begin
        if (!rst_bus_n) begin
            ctrl    <= '0;
            overrun <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            if (accept && we_i && reg_sel == REG_CTRL) ctrl <= dat_i[1:0];
            if (overrun_set)
                overrun <= 1'b1;
            else if (accept && we_i && reg_sel == REG_CLEAR && dat_i[0])
                overrun <= 1'b0;
            irq_o <= (ctrl[CTRL_RX_IE] & (~rx_empty | overrun)) |
                     (ctrl[CTRL_TX_IE] & tx_idle);
        end
    end

    // TX sequencer state register
    always_ff @(posedge clk_bus or negedge rst_bus_n) begin
        if (!rst_bus_n) tx_state <= TX_IDLE;
        else            tx_state <= tx_state_next;
    end

    // TX sequencer: launch head byte when idle, then hold off two cycles
    always_comb begin
        tx_state_next = tx_state;
        tx_pop        = 1'b0;
        uart_start    = 1'b0;
        uart_dat_o    = '0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && !uart_busy) begin
                    uart_start    = 1'b1;
                    uart_dat_o    = tx_head;
                    tx_pop        = 1'b1;
                    tx_state_next = TX_LAUNCH;
                end
            end
            TX_LAUNCH: tx_state_next = TX_GUARD;
            TX_GUARD:  tx_state_next = TX_IDLE;
            default:   tx_state_next = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_uart_fifo_slave.sv
// Self-checking bench: queue-based reference model updated once per cycle,
// expected bus terminations scoreboarded and checked by a separate monitor.
module tb_wb_uart_fifo_slave;
    localparam int RX_DEPTH = 16;
    localparam int TX_DEPTH = 16;

    logic        clk_bus = 1'b0;
    logic        rst_bus_n = 1'b0;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel_i = '0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic        ack_o;
    logic        rty_o;
    logic        err_o;
    logic        stall_o;
    logic        irq_o;
    logic [7:0]  uart_dat_i = '0;
    logic        uart_ready = 1'b0;
    logic        uart_clear;
    logic [7:0]  uart_dat_o;
    logic        uart_start;
    logic        uart_busy = 1'b0;

    wb_uart_fifo_slave #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
        .clk_bus    (clk_bus),
        .rst_bus_n  (rst_bus_n),
        .adr_i      (adr_i),
        .dat_i      (dat_i),
        .dat_o      (dat_o),
        .sel_i      (sel_i),
        .cyc_i      (cyc_i),
        .stb_i      (stb_i),
        .we_i       (we_i),
        .ack_o      (ack_o),
        .rty_o      (rty_o),
        .err_o      (err_o),
        .stall_o    (stall_o),
        .irq_o      (irq_o),
        .uart_dat_i (uart_dat_i),
        .uart_ready (uart_ready),
        .uart_clear (uart_clear),
        .uart_dat_o (uart_dat_o),
        .uart_start (uart_start),
        .uart_busy  (uart_busy)
    );

    always #5 clk_bus = ~clk_bus;

    int tests = 0;
    int fails = 0;

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle counter, used to tag when each termination is due
    int unsigned cyc_n = 0;
    always @(posedge clk_bus) cyc_n <= cyc_n + 1;

    typedef struct {
        int unsigned due;
        bit          rty;
        bit          chk;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic       ovr_m;
    logic [1:0] ctrl_m;
    int         since_start;
    logic       irq_exp;

    // Model: once per cycle, judge the cycle from pre-edge state, then apply its events
    always @(negedge clk_bus) begin : model
        int          n_tx;
        int          n_rx;
        logic        rx_valid_m;
        logic        tx_idle_m;
        logic        exp_start;
        logic        irq_nxt;
        logic [31:0] status_m;
        exp_t        e;
        if (!rst_bus_n) begin
            rx_q.delete();
            tx_q.delete();
            ovr_m       = 1'b0;
            ctrl_m      = 2'b00;
            since_start = 3;
            irq_exp     = 1'b0;
        end else begin
            n_tx       = tx_q.size();
            n_rx       = rx_q.size();
            rx_valid_m = (n_rx != 0);
            tx_idle_m  = (n_tx == 0) && (since_start >= 3);
            status_m   = {8'd0, 8'(n_tx), 8'(n_rx), 4'd0, ovr_m, tx_idle_m,
                          (n_tx < TX_DEPTH), rx_valid_m};

            check_bit("irq", irq_o, irq_exp);
            irq_nxt = (ctrl_m[0] & (rx_valid_m | ovr_m)) | (ctrl_m[1] & tx_idle_m);

            // Transmit launch rule: idle for 3+ cycles, data queued, transmitter free
            exp_start = !uart_busy && (n_tx != 0) && (since_start >= 3);
            if (exp_start || uart_start) check_bit("uart_start", uart_start, exp_start);
            if (exp_start) begin
                check_word("tx_byte", {24'd0, uart_dat_o}, {24'd0, tx_q[0]});
                void'(tx_q.pop_front());
                since_start = 1;
            end else if (since_start < 3) begin
                since_start++;
            end

            if (cyc_i && stb_i) begin
                e.due  = cyc_n + 1;
                e.rty  = 1'b0;
                e.chk  = 1'b0;
                e.data = '0;
                case (adr_i[3:2])
                    2'd0: begin
                        if (we_i) begin
                            if (sel_i[0]) begin
                                if (n_tx == TX_DEPTH) e.rty = 1'b1;
                                else                  tx_q.push_back(dat_i[7:0]);
                            end
                        end else begin
                            e.chk = 1'b1;
                            if (n_rx != 0) e.data = {23'd0, 1'b1, rx_q.pop_front()};
                        end
                    end
                    2'd1: begin
                        e.chk  = !we_i;
                        e.data = status_m;
                    end
                    2'd2: begin
                        e.chk  = !we_i;
                        e.data = {30'd0, ctrl_m};
                        if (we_i) ctrl_m = dat_i[1:0];
                    end
                    default: begin
                        e.chk = !we_i;
                        if (we_i && dat_i[0]) ovr_m = 1'b0;
                    end
                endcase
                exp_q.push_back(e);
            end

            if (uart_ready || uart_clear) check_bit("uart_clear", uart_clear, uart_ready);
            if (uart_ready) begin
                if (rx_q.size() < RX_DEPTH) rx_q.push_back(uart_dat_i);
                else                        ovr_m = 1'b1;
            end
            irq_exp = irq_nxt;
        end
    end

    // Monitor: terminations must appear exactly in the cycle they are due
    always @(negedge clk_bus) begin : monitor
        exp_t e;
        if (rst_bus_n) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc_n) begin
                e = exp_q.pop_front();
                check_bit("ack", ack_o, !e.rty);
                check_bit("rty", rty_o, e.rty);
                if (e.chk && !e.rty) check_word("rdata", dat_o, e.data);
            end else if (ack_o || rty_o) begin
                fails++;
                tests++;
                $display("FAIL spurious_term: got ack=%b rty=%b expected none at %0t", ack_o, rty_o, $time);
            end
            if (err_o || stall_o) check_word("err_stall", {30'd0, err_o, stall_o}, 32'd0);
        end
    end

    // One bus cycle of stimulus; address bits outside [3:2] are randomised
    task automatic drive(input logic c, input logic w, input logic [1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic rdy, input logic [7:0] rb);
        logic [31:0] r;
        r          = $urandom();
        cyc_i      = c;
        stb_i      = c;
        we_i       = w;
        adr_i      = {r[31:4], a, r[1:0]};
        dat_i      = d;
        sel_i      = s;
        uart_ready = rdy;
        uart_dat_i = rb;
        @(posedge clk_bus);
        #1;
        cyc_i      = 1'b0;
        stb_i      = 1'b0;
        we_i       = 1'b0;
        uart_ready = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d, 4'hF, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [1:0] a);
        drive(1'b1, 1'b0, a, 32'd0, 4'hF, 1'b0, 8'h00);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 4'h0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_bus);
            #1;
        end
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state of every output
        repeat (3) @(posedge clk_bus);
        @(negedge clk_bus);
        check_bit("rst_ack", ack_o, 1'b0);
        check_bit("rst_rty", rty_o, 1'b0);
        check_bit("rst_irq", irq_o, 1'b0);
        check_bit("rst_start", uart_start, 1'b0);
        check_bit("rst_clear", uart_clear, 1'b0);
        check_word("rst_dat", dat_o, 32'd0);
        @(posedge clk_bus);
        #1;
        rst_bus_n = 1'b1;
        idle(2);

        // STATUS after reset
        rd(2'd1);

        // Two back-to-back TX writes, launch spacing, idle again
        uart_busy = 1'b0;
        wr(2'd0, 32'h41);
        wr(2'd0, 32'h42);
        idle(10);
        rd(2'd1);

        // Write with sel_i[0]=0 has no effect
        drive(1'b1, 1'b1, 2'd0, 32'h99, 4'hE, 1'b0, 8'h00);
        idle(4);

        // Fill TX while transmitter busy; last write retried
        uart_busy = 1'b1;
        for (int i = 0; i < TX_DEPTH + 1; i++) wr(2'd0, 32'h60 + i);
        rd(2'd1);
        uart_busy = 1'b0;
        idle(3 * TX_DEPTH + 10);
        rd(2'd1);

        // RX overrun, read, clear
        for (int i = 0; i < RX_DEPTH + 1; i++) rx_byte(8'h55);
        rd(2'd1);
        rd(2'd0);
        wr(2'd3, 32'd1);
        rd(2'd1);
        for (int i = 0; i < RX_DEPTH; i++) rd(2'd0);

        // RX interrupt
        wr(2'd2, 32'd1);
        rd(2'd2);
        rx_byte(8'h7E);
        idle(3);
        rd(2'd0);
        idle(3);

        // TX idle interrupt
        wr(2'd2, 32'd2);
        idle(3);
        wr(2'd0, 32'h33);
        idle(6);
        wr(2'd2, 32'd0);

        // RX full with push and pop in the same cycle
        for (int i = 0; i < RX_DEPTH; i++) rx_byte(8'(i + 1));
        drive(1'b1, 1'b0, 2'd0, 32'd0, 4'hF, 1'b1, 8'hAA);
        rd(2'd1);
        for (int i = 0; i < RX_DEPTH + 1; i++) rd(2'd0);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            logic        c;
            logic        w;
            logic [1:0]  a;
            logic        rdy;
            c         = ($urandom_range(0, 9) < 7);
            w         = $urandom_range(0, 1) == 1;
            a         = ($urandom_range(0, 3) < 2) ? 2'd0 : 2'($urandom_range(1, 3));
            rdy       = ($urandom_range(0, 9) < 3);
            uart_busy = ($urandom_range(0, 9) < 3);
            drive(c, w, a, $urandom(), 4'($urandom()), rdy, 8'($urandom()));
        end

        // Drain and finish
        uart_busy = 1'b0;
        idle(3 * TX_DEPTH + 20);
        for (int i = 0; i < RX_DEPTH + 1; i++) rd(2'd0);
        rd(2'd1);
        idle(5);
        check_word("pending_terms", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
